// File: rtl/alu_mdu_if.sv
// Request/result bundle between a requester and the ALU/MDU.
// The master drives the operation; the slave returns status and results.
interface alu_mdu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       ctl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             ovf;
  logic             dz;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, ctl, a, b,
    input  busy, done, result, zero, ovf, dz, hi, lo
  );

  modport slave (
    input  start, ctl, a, b,
    output busy, done, result, zero, ovf, dz, hi, lo
  );
endinterface

// File: rtl/alu_mdu.sv
// Single-cycle ALU plus iterative unsigned multiply/divide unit.
// Multiply is shift-add, divide is restoring; both take WIDTH steps.
module alu_mdu #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_mdu_if.slave io
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_XOR  = 4'b1101;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_DIV  = 4'b1001;
  localparam logic [3:0] OP_MFHI = 4'b1010;
  localparam logic [3:0] OP_MFLO = 4'b1011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;
  logic               dz_q, dz_d;

  logic               wr;
  logic [WIDTH-1:0]   wres;
  logic               wovf;
  logic               wdz;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;
  logic [WIDTH:0]     mstep;
  logic [WIDTH:0]     dshift;
  logic [WIDTH:0]     dtrial;
  logic               last;

  assign sum  = io.a + io.b;
  assign diff = io.a - io.b;

  // acc holds {partial product, remaining multiplier} or {remainder, quotient}
  assign mstep  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign dshift = acc_q[2*WIDTH-1:WIDTH-1];
  assign dtrial = dshift - {1'b0, opb_q};
  assign last   = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    res_d   = res_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;
    wr      = 1'b0;
    wres    = '0;
    wovf    = 1'b0;
    wdz     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (io.start) begin
          state_d = S_DONE;
          wr      = 1'b1;
          cnt_d   = '0;
          opb_d   = io.b;
          case (io.ctl)
            OP_AND:  wres = io.a & io.b;
            OP_OR:   wres = io.a | io.b;
            OP_NOR:  wres = ~(io.a | io.b);
            OP_XOR:  wres = io.a ^ io.b;
            OP_ADD: begin
              wres = sum;
              wovf = (io.a[WIDTH-1] == io.b[WIDTH-1])
                  && (sum[WIDTH-1] != io.a[WIDTH-1]);
            end
            OP_SUB: begin
              wres = diff;
              wovf = (io.a[WIDTH-1] != io.b[WIDTH-1])
                  && (diff[WIDTH-1] != io.a[WIDTH-1]);
            end
            OP_SLT: begin
              wres = {{(WIDTH-1){1'b0}},
                      $signed(io.a) < $signed(io.b)};
            end
            OP_MFHI: wres = hi_q;
            OP_MFLO: wres = lo_q;
            OP_MUL: begin
              state_d = S_MUL;
              wr      = 1'b0;
              acc_d   = {{WIDTH{1'b0}}, io.a};
            end
            OP_DIV: begin
              if (io.b == '0) begin
                wres = '1;
                wdz  = 1'b1;
                hi_d = io.a;
                lo_d = '1;
              end else begin
                state_d = S_DIV;
                wr      = 1'b0;
                acc_d   = {{WIDTH{1'b0}}, io.a};
              end
            end
            default: wres = '0;
          endcase
        end
      end
      S_MUL: begin
        acc_d = {mstep, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          state_d = S_DONE;
          hi_d    = acc_d[2*WIDTH-1:WIDTH];
          lo_d    = acc_d[WIDTH-1:0];
          wr      = 1'b1;
          wres    = acc_d[WIDTH-1:0];
        end
      end
      S_DIV: begin
        if (dtrial[WIDTH]) begin
          acc_d = {dshift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {dtrial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          state_d = S_DONE;
          hi_d    = acc_d[2*WIDTH-1:WIDTH];
          lo_d    = acc_d[WIDTH-1:0];
          wr      = 1'b1;
          wres    = acc_d[WIDTH-1:0];
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (wr) begin
      res_d  = wres;
      zero_d = (wres == '0);
      ovf_d  = wovf;
      dz_d   = wdz;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      opb_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
    end
  end

  assign io.busy   = (state_q != S_IDLE);
  assign io.done   = (state_q == S_DONE);
  assign io.result = res_q;
  assign io.zero   = zero_q;
  assign io.ovf    = ovf_q;
  assign io.dz     = dz_q;
  assign io.hi     = hi_q;
  assign io.lo     = lo_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Bench for alu_mdu: directed literal cases plus random traffic
// checked every cycle against an arithmetic reference model.
module tb_alu_mdu;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  alu_mdu_if #(.WIDTH(W)) bus ();

  alu_mdu #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] res;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        ovf;
    logic        dz;
    int          lat;
  } op_t;

  // Reference: plain arithmetic on the requested operation.
  function automatic op_t model_op(input logic [3:0] c,
                                   input logic [31:0] x, y, h, l);
    op_t r;
    longint s;
    logic [63:0] p;
    longint lim;
    lim = longint'(1) <<< 31;
    r.res = '0; r.hi = h; r.lo = l; r.ovf = 1'b0; r.dz = 1'b0; r.lat = 1;
    case (c)
      4'b0000: r.res = x & y;
      4'b0001: r.res = x | y;
      4'b1100: r.res = ~(x | y);
      4'b1101: r.res = x ^ y;
      4'b0010: begin
        s = longint'($signed(x)) + longint'($signed(y));
        r.res = x + y;
        r.ovf = (s >= lim) || (s < -lim);
      end
      4'b0110: begin
        s = longint'($signed(x)) - longint'($signed(y));
        r.res = x - y;
        r.ovf = (s >= lim) || (s < -lim);
      end
      4'b0111: r.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'b1010: r.res = h;
      4'b1011: r.res = l;
      4'b1000: begin
        p = 64'(x) * 64'(y);
        r.hi = p[63:32]; r.lo = p[31:0]; r.res = p[31:0]; r.lat = W + 1;
      end
      4'b1001: begin
        if (y == 0) begin
          r.lo = '1; r.hi = x; r.dz = 1'b1; r.res = '1;
        end else begin
          r.lo = x / y; r.hi = x % y; r.res = x / y; r.lat = W + 1;
        end
      end
      default: r.res = '0;
    endcase
    return r;
  endfunction

  int          m_left = 0;
  logic [31:0] m_res = '0, m_hi = '0, m_lo = '0;
  logic        m_zero = 1'b0, m_ovf = 1'b0, m_dz = 1'b0;
  op_t         pend;

  task automatic apply(input op_t o);
    m_res = o.res; m_zero = (o.res == 0); m_ovf = o.ovf;
    m_dz = o.dz; m_hi = o.hi; m_lo = o.lo;
  endtask

  // m_left counts cycles until the done cycle; 0 means idle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0; m_res = '0; m_hi = '0; m_lo = '0;
      m_zero = 1'b0; m_ovf = 1'b0; m_dz = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 1) apply(pend);
    end else if (bus.start) begin
      pend = model_op(bus.ctl, bus.a, bus.b, m_hi, m_lo);
      m_left = pend.lat;
      if (m_left == 1) apply(pend);
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("busy",   64'(bus.busy),   64'(m_left > 0));
      chk("done",   64'(bus.done),   64'(m_left == 1));
      chk("result", 64'(bus.result), 64'(m_res));
      chk("zero",   64'(bus.zero),   64'(m_zero));
      chk("ovf",    64'(bus.ovf),    64'(m_ovf));
      chk("dz",     64'(bus.dz),     64'(m_dz));
      chk("hi",     64'(bus.hi),     64'(m_hi));
      chk("lo",     64'(bus.lo),     64'(m_lo));
    end
  end

  function automatic logic [31:0] rnd();
    int unsigned k;
    k = $urandom % 6;
    case (k)
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'h7FFFFFFF;
      4: return 32'($urandom % 16);
      default: return 32'($urandom);
    endcase
  endfunction

  // Issues one op from idle and returns at the negedge where done is seen.
  task automatic run_op(input logic [3:0] c, input logic [31:0] x, y,
                        input int poke, output int lat);
    @(negedge clk);
    bus.start = 1'b1; bus.ctl = c; bus.a = x; bus.b = y;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 100) begin
      bus.a = 32'($urandom); bus.b = 32'($urandom);
      if (lat == poke) begin
        bus.start = 1'b1; bus.ctl = 4'b0010;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    if (!bus.done) begin
      n_vec++; n_err++;
      $display("FAIL timeout: got no done expected done within 100 cycles");
    end
  endtask

  initial begin
    int lat;
    int seen;
    bus.start = 1'b0; bus.ctl = '0; bus.a = '0; bus.b = '0;
    chk_on = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_res",  64'(bus.result), 64'(0));
    rst_n = 1'b1;

    run_op(4'b0010, 32'h7FFFFFFF, 32'h1, -1, lat);
    chk("add_lat", 64'(lat), 64'(1));
    chk("add_res", 64'(bus.result), 64'h80000000);
    chk("add_ovf", 64'(bus.ovf), 64'(1));
    chk("add_zero", 64'(bus.zero), 64'(0));

    run_op(4'b0110, 32'd5, 32'd5, -1, lat);
    chk("sub_res", 64'(bus.result), 64'(0));
    chk("sub_zero", 64'(bus.zero), 64'(1));
    chk("sub_ovf", 64'(bus.ovf), 64'(0));

    run_op(4'b0111, 32'hFFFFFFFF, 32'h1, -1, lat);
    chk("slt_res", 64'(bus.result), 64'(1));

    run_op(4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, lat);
    chk("mul_lat", 64'(lat), 64'(33));
    chk("mul_hi", 64'(bus.hi), 64'hFFFFFFFE);
    chk("mul_lo", 64'(bus.lo), 64'h1);
    run_op(4'b1010, 32'h0, 32'h0, -1, lat);
    chk("mfhi_res", 64'(bus.result), 64'hFFFFFFFE);

    run_op(4'b1001, 32'd100, 32'd7, -1, lat);
    chk("div_lat", 64'(lat), 64'(33));
    chk("div_lo", 64'(bus.lo), 64'(14));
    chk("div_hi", 64'(bus.hi), 64'(2));
    chk("div_dz", 64'(bus.dz), 64'(0));
    run_op(4'b1001, 32'd9, 32'd0, -1, lat);
    chk("dz_lat", 64'(lat), 64'(1));
    chk("dz_flag", 64'(bus.dz), 64'(1));
    chk("dz_lo", 64'(bus.lo), 64'hFFFFFFFF);
    chk("dz_hi", 64'(bus.hi), 64'(9));

    // Abort a multiply with reset partway through.
    @(negedge clk);
    bus.start = 1'b1; bus.ctl = 4'b1000; bus.a = 32'd3; bus.b = 32'd4;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(bus.busy), 64'(0));
    chk("abort_res", 64'(bus.result), 64'(0));
    chk("abort_hi", 64'(bus.hi), 64'(0));
    chk("abort_lo", 64'(bus.lo), 64'(0));
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    chk("abort_nodone", 64'(seen), 64'(0));
    run_op(4'b0010, 32'd2, 32'd3, -1, lat);
    chk("post_rst_add", 64'(bus.result), 64'(5));

    // Stray start during a multiply must be ignored.
    run_op(4'b1000, 32'h12345, 32'h6789, 5, lat);
    chk("poke_lat", 64'(lat), 64'(33));
    chk("poke_lo", 64'(bus.lo), 64'h75CCA2ED);
    chk("poke_hi", 64'(bus.hi), 64'(0));
    run_op(4'b1111, 32'd1, 32'd2, -1, lat);
    chk("ill_res", 64'(bus.result), 64'(0));
    chk("ill_zero", 64'(bus.zero), 64'(1));
    chk("ill_lo", 64'(bus.lo), 64'h75CCA2ED);
    chk("ill_hi", 64'(bus.hi), 64'(0));

    // Held start: back-to-back simple ops.
    repeat (30) begin
      @(negedge clk);
      bus.start = 1'b1; bus.ctl = 4'b0010; bus.a = rnd(); bus.b = rnd();
    end

    repeat (4000) begin
      @(negedge clk);
      bus.start = ($urandom % 4) != 0;
      bus.ctl = 4'($urandom);
      bus.a = rnd();
      bus.b = rnd();
    end
    @(negedge clk);
    bus.start = 1'b0;
    repeat (40) @(negedge clk);
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 Parameter WIDTH, default 32; datapath width in bits; legal values 8 to 64, even.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  operation request; sampled on rising edge only when busy=0.
REQ-005 ctl  input  4  operation select, captured with start.
REQ-006 a  input  WIDTH  operand A, captured with start.
REQ-007 b  input  WIDTH  operand B, captured with start.
REQ-008 busy  output  1  high while an accepted operation is in progress or in DONE.
REQ-009 done  output  1  one-cycle pulse; result, zero, ovf, dz, hi, lo valid while high.
REQ-010 result  output  WIDTH  registered result; holds until the next done.
REQ-011 zero  output  1  high when result == 0; updated only with done.
REQ-012 ovf  output  1  signed overflow for ADD/SUB; 0 for all other ops.
REQ-013 dz  output  1  divide-by-zero flag for DIVU; 0 for all other ops.
REQ-014 hi, lo  output  WIDTH each  multiply/divide result registers.

Function
REQ-015 ctl encoding: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 1100 NOR, 1101 XOR, 1000 MULTU, 1001 DIVU, 1010 MFHI, 1011 MFLO; all other codes are illegal.
REQ-016 FSM states IDLE, MUL, DIV, DONE; busy = (state != IDLE); done = (state == DONE).
REQ-017 IDLE with start=1: capture ctl/a/b; MULTU -> MUL; DIVU with b!=0 -> DIV; all other codes -> DONE.
REQ-018 Simple ops (AND..XOR, SLT, MFHI, MFLO, illegal): done high in the cycle after the accepting edge (latency 1).
REQ-019 MUL: unsigned shift-add, one partial product per cycle, exactly WIDTH cycles, then DONE; done high WIDTH+1 cycles after accept; {hi,lo} = a*b (2*WIDTH bits, no truncation).
REQ-020 DIV: unsigned restoring division, one quotient bit per cycle, exactly WIDTH cycles, then DONE; lo = a/b, hi = a%b.
REQ-021 MULTU/DIVU drive result = lo at done; hi and lo are otherwise unchanged by all other ops.
REQ-022 DIVU with b=0: skip DIV, go directly to DONE (latency 1); lo = all ones, hi = a, dz=1, result = all ones.
REQ-023 ADD/SUB: result modulo 2^WIDTH; ovf=1 when operand signs imply a signed-overflow condition (ADD: a,b same sign, result sign differs; SUB: a,b differ in sign, result sign differs from a).
REQ-024 SLT: result = 1 if $signed(a) < $signed(b), else 0; never overflows.
REQ-025 MFHI/MFLO: result = current hi/lo register value.
REQ-026 Illegal ctl: result = 0, zero=1, ovf=0, dz=0; hi/lo unchanged.
REQ-027 DONE -> IDLE unconditionally after one cycle; start asserted during MUL, DIV or DONE is ignored, not queued.
REQ-028 Operand inputs may change after the accepting edge without affecting the operation in progress.
REQ-029 Back-to-back: start held high continuously yields one accepted op per (latency+1) cycles.

Reset
REQ-030 rst_n=0 immediately forces state=IDLE, busy=0, done=0, result=0, zero=0, ovf=0, dz=0, hi=0, lo=0, iteration counter=0.
REQ-031 Reset asserted mid-MUL or mid-DIV aborts the operation; no done pulse is produced and hi/lo read 0 afterward.
REQ-032 First start is accepted on the first rising edge after rst_n deasserts.

Verification (WIDTH=32)
REQ-033 ADD a=0x7FFFFFFF, b=1 -> done 1 cycle later, result=0x80000000, ovf=1, zero=0.
REQ-034 SUB a=5, b=5 -> result=0, zero=1, ovf=0; SLT a=0xFFFFFFFF, b=1 -> result=1.
REQ-035 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> busy for 33 cycles, done on cycle 33, hi=0xFFFFFFFE, lo=0x00000001; then MFHI -> result=0xFFFFFFFE.
REQ-036 DIVU a=100, b=7 -> done on cycle 33, lo=14, hi=2, dz=0; DIVU a=9, b=0 -> done 1 cycle later, dz=1, lo=0xFFFFFFFF, hi=9.
REQ-037 Start MULTU, assert rst_n=0 at cycle 10, release -> no done pulse, all outputs 0, next ADD 2+3 -> result=5.
REQ-038 Start pulsed during MUL busy and ctl=1111 illegal op -> pulse ignored; illegal op gives result=0, zero=1, hi/lo unchanged.
